// File: rtl/thre_bin_pkg.sv
// Shared types and parameter-derivation helpers for the threshold binarizer.
// Every width here is derived from the top-level parameters, so the sub-module and the top cannot disagree.
package thre_bin_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      RUN   = 2'd2
   } state_t;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int thr_per_word(input int data_width, input int thr_width);
      return data_width / thr_width;
   endfunction

   function automatic int word_count(input int channels, input int data_width,
                                     input int thr_width);
      return channels / thr_per_word(data_width, thr_width);
   endfunction

   function automatic int lane_width(input int data_width, input int thr_width);
      return clog2_min1(thr_per_word(data_width, thr_width));
   endfunction

   function automatic int word_idx_width(input int channels, input int data_width,
                                         input int thr_width);
      return clog2_min1(word_count(channels, data_width, thr_width));
   endfunction

endpackage

// File: rtl/threshold_compare.sv
// Selects one signed threshold lane from a packed ROM word, sign-extends it to the accumulator width,
// and produces the activation bit (acc >= threshold).
module threshold_compare
   import thre_bin_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int THR_WIDTH  = 16,
   parameter int ACC_WIDTH  = 16,
   parameter int LANE_WIDTH = 1
) (
   input  logic        [DATA_WIDTH-1:0] rom_data,
   input  logic        [LANE_WIDTH-1:0] lane,
   input  logic signed [ACC_WIDTH-1:0]  acc_data,
   output logic                         act_bit
);

   localparam int TPW = thr_per_word(DATA_WIDTH, THR_WIDTH);

   logic signed [THR_WIDTH-1:0] thr;
   logic signed [ACC_WIDTH-1:0] thr_ext;

   // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
   always_comb begin
      thr = '0;
      for (int l = 0; l < TPW; l++) begin
         if (lane == LANE_WIDTH'(l)) begin
            thr = rom_data[l*THR_WIDTH +: THR_WIDTH];
         end
      end
      // Size cast of a signed operand sign-extends.
      thr_ext = ACC_WIDTH'(thr);
      act_bit = (acc_data >= thr_ext);
   end

endmodule

// File: rtl/threshold_binarizer.sv
// Binarization stage: compares per-channel accumulators with ROM thresholds and packs the sign bits per frame.
// Optional THRE_PREFETCH_EN: fetch the next ROM word in the same cycle the last lane is accepted (no bubbles).
module threshold_binarizer
   import thre_bin_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int THR_WIDTH  = 16,
   parameter int ACC_WIDTH  = 16,
   parameter int CHANNELS   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         acc_valid,
   input  logic signed [ACC_WIDTH-1:0]  acc_data,
   output logic                         acc_ready,
   output logic                         rom_en,
   output logic        [ADDR_WIDTH-1:0] rom_addr,
   input  logic        [DATA_WIDTH-1:0] rom_data,
   output logic                         out_valid,
   output logic        [CHANNELS-1:0]   out_data,
   input  logic                         out_ready
);

   localparam int TPW        = thr_per_word(DATA_WIDTH, THR_WIDTH);
   localparam int WORD_COUNT = word_count(CHANNELS, DATA_WIDTH, THR_WIDTH);
   localparam int LW         = lane_width(DATA_WIDTH, THR_WIDTH);
   localparam int WW         = word_idx_width(CHANNELS, DATA_WIDTH, THR_WIDTH);
   localparam int CW         = clog2_min1(CHANNELS);

   state_t                state;
   logic [LW-1:0]         lane;
   logic [WW-1:0]         word_idx;
   logic [WW-1:0]         word_next;
   logic [CHANNELS-1:0]   pack;
   logic [CHANNELS-1:0]   pack_next;
   logic [CW-1:0]         chan;
   logic                  accept;
   logic                  last_lane;
   logic                  last_word;
   logic                  frame_end;
   logic                  act_bit;

   threshold_compare #(
      .DATA_WIDTH (DATA_WIDTH),
      .THR_WIDTH  (THR_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .LANE_WIDTH (LW)
   ) u_compare (
      .rom_data (rom_data),
      .lane     (lane),
      .acc_data (acc_data),
      .act_bit  (act_bit)
   );

   assign acc_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept    = acc_valid && acc_ready;
   assign last_lane = (lane == LW'(TPW - 1));
   assign last_word = (word_idx == WW'(WORD_COUNT - 1));
   assign frame_end = accept && last_lane && last_word;
   assign word_next = last_word ? '0 : word_idx + 1'b1;
   assign chan      = CW'(int'(word_idx) * TPW + int'(lane));

   always_comb begin
      pack_next       = pack;
      pack_next[chan] = act_bit;
   end

   // ROM request: the FETCH state reads the current word; with prefetch, the last-lane accept reads the next one.
   always_comb begin
      rom_en   = (state == FETCH);
      rom_addr = ADDR_WIDTH'(word_idx);
`ifdef THRE_PREFETCH_EN
      if (state == RUN && accept && last_lane) begin
         rom_en   = 1'b1;
         rom_addr = ADDR_WIDTH'(word_next);
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         word_idx  <= '0;
         lane      <= '0;
         pack      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE:  state <= FETCH;
            FETCH: state <= RUN;
            RUN: begin
               if (accept) begin
                  if (last_lane) begin
                     lane     <= '0;
                     word_idx <= word_next;
`ifdef THRE_PREFETCH_EN
                     state    <= RUN;
`else
                     state    <= FETCH;
`endif
                  end else begin
                     lane <= lane + 1'b1;
                  end
                  // A frame-end load wins over the handshake clear above.
                  if (frame_end) begin
                     out_data  <= pack_next;
                     out_valid <= 1'b1;
                     pack      <= '0;
                  end else begin
                     pack <= pack_next;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/threshold_binarizer.md
# threshold_binarizer

Binarization stage that sits directly downstream of a per-block threshold ROM in the BNN ECG accelerator. It accepts one signed popcount accumulator per output channel in channel order and fetches the matching packed threshold words from the ROM. Each accumulator is compared against its threshold, and the resulting sign bits are packed into one CHANNELS-bit activation word per frame for the next binary convolution block.

## Interface
- ADDR_WIDTH, 8: ROM address width.
- DATA_WIDTH, 32: ROM word width.
- THR_WIDTH, 16: one signed threshold; THR_PER_WORD = DATA_WIDTH/THR_WIDTH (must divide exactly).
- ACC_WIDTH, 16: signed accumulator width; must satisfy ACC_WIDTH >= THR_WIDTH.
- CHANNELS, 4: channels per frame; must be a multiple of THR_PER_WORD; ROM depth = CHANNELS/THR_PER_WORD.
- clk  in  1  clock; all logic on the posedge.
- rst  in  1  synchronous, active-high reset.
- acc_valid  in  1  accumulator present.
- acc_data  in  ACC_WIDTH  signed accumulator for the current channel.
- acc_ready  out  1  accumulator accepted this cycle when high together with acc_valid.
- rom_en  out  1  ROM read enable (combinational).
- rom_addr  out  ADDR_WIDTH  ROM word index (combinational).
- rom_data  in  DATA_WIDTH  registered ROM output, valid the cycle after rom_en, held while rom_en is low.
- out_valid  out  1  packed activation word available.
- out_data  out  CHANNELS  bit c = activation of channel c.
- out_ready  in  1  consumer accepts out_data.

## Operation
- States: IDLE, FETCH, RUN.
- IDLE: entered on reset. Always moves to FETCH on the next cycle.
- FETCH: rom_en=1, rom_addr=word_idx. Always moves to RUN on the next cycle, when rom_data is valid.
- RUN: acc_ready = !out_valid || out_ready.
  - On each accepted accumulator, channel c = word_idx*THR_PER_WORD + lane.
  - Threshold = rom_data[lane*THR_WIDTH +: THR_WIDTH], sign-extended to ACC_WIDTH.
  - Activation bit = (signed acc_data >= threshold), i.e. +1 maps to 1 and -1 maps to 0.
  - The bit is written into the pack register at position c.
- Lane wrap (lane = THR_PER_WORD-1 accepted):
  - lane returns to 0.
  - word_idx increments, or wraps to 0 after the last word.
  - Next state is FETCH (prefetch behaviour is described under Configuration).
- Frame end (channel CHANNELS-1 accepted):
  - out_data <= pack register including the current bit; out_valid <= 1.
  - The pack register is cleared.
- out_valid stays high until out_ready is sampled high. Simultaneous out_ready and a last-channel accept loads the new word with out_valid remaining 1.
- Reset at any point discards the partial frame and the pending output, and restarts from word 0.

## Timing
- Reset values: out_valid=0, out_data=0, acc_ready=0, rom_en=0, rom_addr=0, state=IDLE, word_idx=0, lane=0, pack=0.
- First acc_ready is 2 cycles after rst deasserts (IDLE, then FETCH).
- Latency from the last-channel accept to out_valid high is 1 cycle.
- Throughput without prefetch: THR_PER_WORD accepts per THR_PER_WORD+1 cycles.
- Backpressure: acc_ready is 0 while out_valid=1 and out_ready=0, even mid-frame.
- acc_data is ignored when acc_valid=0. No state changes occur in RUN without an accept.

## Configuration
- THRE_PREFETCH_EN defined:
  - In the cycle the last lane of a word is accepted, rom_en=1 and rom_addr=next word_idx.
  - The state stays RUN, so the next word is in rom_data on the following cycle.
  - Result: zero bubble cycles, including across the frame wrap to word 0.
  - rom_en is also asserted in the FETCH state.
- THRE_PREFETCH_EN undefined: one FETCH bubble cycle per ROM word, as described in Operation.

## Structure
- Package thre_bin_pkg holds:
  - the state enum (IDLE, FETCH, RUN);
  - helper functions deriving THR_PER_WORD, WORD_COUNT, LANE_WIDTH and WORD_IDX_WIDTH from the parameters.
- One sub-module, threshold_compare: combinational lane select from rom_data, sign extension, and signed >= compare producing one bit.
- Top level holds the FSM, counters, pack register and output register.

## Test plan
Defaults apply. ROM word0 = {thr1=-3, thr0=5}; word1 = {thr3=0, thr2=100}.
- Reset then continuous acc_valid with acc = 5, -4, 99, 0:
  - out_data = 4'b1001, out_valid 1 cycle after the 4th accept.
  - rom_addr sequence 0, 1, then 0.
- Boundary equality, acc = 5, -3, 100, 0: out_data = 4'b1111.
- Extremes, acc = -32768 and 32767 against thr=5: bits 0 and 1 respectively.
- out_ready held low for 10 cycles after the first frame:
  - acc_ready stays 0 and out_data stays 4'b1001.
  - Second frame (acc = 4, -3, 0, -1) then yields 4'b0010.
- Reset asserted after 2 accepts, then a full frame of 5, -4, 99, 0: only 4'b1001 is produced and no stale bits appear.
- With and without THRE_PREFETCH_EN, 8 back-to-back frames: outputs are identical. Accept count over 40 cycles is 40 minus startup with the macro, and 2/3 of the RUN-phase rate without it.
